// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery and status bundle between uart_rx and its consumer.
// Handshake: O_valid high means O_data holds an unconsumed byte; the consumer
// takes it on any rising I_clk edge where O_valid && I_ready, and O_data does
// not change while O_valid is high and the byte has not been taken.
// O_frame_err, O_parity_err and O_overrun are single-cycle pulses.
interface uart_rx_if;
  logic [7:0] O_data;
  logic       O_valid;
  logic       I_ready;
  logic       O_busy;
  logic       O_frame_err;
  logic       O_parity_err;
  logic       O_overrun;

  modport master (
    output O_data, O_valid, O_busy, O_frame_err, O_parity_err, O_overrun,
    input  I_ready
  );

  modport slave (
    input  O_data, O_valid, O_busy, O_frame_err, O_parity_err, O_overrun,
    output I_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1 by default, 8E1 when the macro
// UART_RX_PARITY_EN is defined. Bytes are recovered LSB first with 3-sample
// majority voting at mid-bit and handed over through a one-entry holding
// register. O_dbg_state exposes the receive FSM state (IDLE reads as 0).
module uart_rx #(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_rx,
  uart_rx_if.master  bus,
  output logic [2:0] O_dbg_state
);

  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be at least 8");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [1:0]       sync_fill;
  logic [2:0]       samp;
  logic             maj;
  logic             start_edge;
  logic             sample_now;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bad;
  logic             stop_now;
  logic             good_byte;

  // Synchronizer, edge history and 3-sample vote window. rx_sync only carries
  // real line data two cycles after reset; until then rx_prev ignores it, so a
  // line held low through reset never looks like a falling edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b0;
      sync_fill <= 2'b00;
      samp      <= 3'b111;
    end else begin
      rx_meta   <= I_rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_sync & sync_fill[1];
      samp      <= {samp[1:0], rx_sync};
    end
  end

  assign maj        = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign start_edge = rx_prev & ~rx_sync;
  assign sample_now = (cnt == '0);
  assign stop_now   = (state == S_STOP) && sample_now;

`ifdef UART_RX_PARITY_EN
  logic par_flag;
  assign par_bad = par_flag;
`else
  assign par_bad = 1'b0;
`endif

  assign good_byte   = stop_now && maj && !par_bad;
  assign O_dbg_state = state;
  assign bus.O_busy  = (state != S_IDLE);

  // Receive FSM: bit timing, data shifting and parity accumulation.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_flag <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state <= S_START;
            cnt   <= HALF_LOAD;
          end
        end
        S_START: begin
          if (sample_now) begin
            if (maj) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_flag <= 1'b0;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (sample_now) begin
            shreg <= {maj, shreg[7:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (sample_now) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_flag <= ^{shreg, maj};
            cnt      <= FULL_LOAD;
            state    <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (sample_now) begin
            state <= maj ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_sync) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register and status pulses, updated at the stop-bit sample edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      bus.O_data      <= 8'h00;
      bus.O_valid     <= 1'b0;
      bus.O_frame_err <= 1'b0;
      bus.O_overrun   <= 1'b0;
    end else begin
      bus.O_frame_err <= stop_now && !maj;
      bus.O_overrun   <= good_byte && bus.O_valid && !bus.I_ready;
      if (good_byte && (!bus.O_valid || bus.I_ready)) begin
        bus.O_data  <= shreg;
        bus.O_valid <= 1'b1;
      end else if (bus.O_valid && bus.I_ready) begin
        bus.O_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, concurrent with a frame error when both occur.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      bus.O_parity_err <= 1'b0;
    end else begin
      bus.O_parity_err <= stop_now && par_bad;
    end
  end
`else
  assign bus.O_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed stimulus for uart_rx with a frame-level
// reference model (good byte / framing / parity / overrun rules) and a
// scoreboard of expected delivered bytes.
module tb_uart_rx;
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif
  // Line falls just after edge P0; two synchronizer flops put t0 at P2.
  // Delivery is t0 + CPB/2 + FRAME_BITS*CPB + 1.
  localparam int DELIVER_LAT = 2 + CPB / 2 + FRAME_BITS * CPB + 1;

  logic       I_clk = 1'b0;
  logic       I_rst = 1'b1;
  logic       I_rx  = 1'b1;
  logic [2:0] dbg_state;

  uart_rx_if rx_bus ();

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_rx       (I_rx),
    .bus        (rx_bus),
    .O_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 I_clk = ~I_clk;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         exp_frame = 0;
  int         exp_par   = 0;
  int         exp_over  = 0;
  logic       hold_full = 1'b0;

  // written only by the monitor
  int         obs_frame = 0;
  int         obs_par   = 0;
  int         obs_over  = 0;
  int         obs_pop   = 0;
  int         busy_cycles = 0;
  logic [7:0] obs_arr[256];

  // read index into obs_arr, owned by the main sequence
  int rd_idx = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge I_clk) begin
    if (!I_rst) begin
      if (rx_bus.O_frame_err)  obs_frame++;
      if (rx_bus.O_parity_err) obs_par++;
      if (rx_bus.O_overrun)    obs_over++;
      if (rx_bus.O_busy)       busy_cycles++;
      if (rx_bus.O_valid && rx_bus.I_ready) begin
        obs_arr[obs_pop & 255] = rx_bus.O_data;
        obs_pop++;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    logic par_bad;
`ifdef UART_RX_PARITY_EN
    par_bad = par_flip;
`else
    par_bad = 1'b0;
`endif
    if (!stop_v) exp_frame++;
    if (par_bad) exp_par++;
    if (stop_v && !par_bad) begin
      if (hold_full && !rx_bus.I_ready) begin
        exp_over++;
      end else begin
        exp_q.push_back(b);
        hold_full = !rx_bus.I_ready;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic hold_line(input logic v, input int n);
    I_rx = v;
    repeat (n) begin
      @(posedge I_clk);
      #1;
    end
  endtask

  task automatic set_ready(input logic v);
    rx_bus.I_ready = v;
    if (v) hold_full = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold_line((^b) ^ par_flip, CPB);
`endif
    model_frame(b, stop_v, par_flip);
    hold_line(stop_v, CPB);
    if (!stop_v) begin
      hold_line(1'b0, 40);
      hold_line(1'b1, CPB);
    end
  endtask

  task automatic drain_compare(input string tag);
    check_eq({tag, "_count"}, obs_pop - rd_idx, exp_q.size());
    while (rd_idx < obs_pop && exp_q.size() > 0) begin
      check_eq(tag, obs_arr[rd_idx & 255], exp_q.pop_front());
      rd_idx++;
    end
    rd_idx = obs_pop;
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_frame_err"},  obs_frame, exp_frame);
    check_eq({tag, "_parity_err"}, obs_par,   exp_par);
    check_eq({tag, "_overrun"},    obs_over,  exp_over);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    rx_bus.I_ready = 1'b1;

    // reset state
    repeat (5) @(posedge I_clk);
    @(negedge I_clk);
    check_eq("reset_data",      rx_bus.O_data, 8'h00);
    check_eq("reset_valid",     rx_bus.O_valid, 1'b0);
    check_eq("reset_busy",      rx_bus.O_busy, 1'b0);
    check_eq("reset_frame_err", rx_bus.O_frame_err, 1'b0);
    check_eq("reset_par_err",   rx_bus.O_parity_err, 1'b0);
    check_eq("reset_overrun",   rx_bus.O_overrun, 1'b0);
    check_eq("reset_dbg_state", dbg_state, 3'd0);
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    hold_line(1'b1, 10);

    // byte 0xA5 with delivery latency measured from the line fall
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin : lat_probe
        int  d;
        bit  seen;
        d    = 0;
        seen = 1'b0;
        while (!seen && d < 400) begin
          @(negedge I_clk);
          if (rx_bus.O_valid) seen = 1'b1;
          else d++;
        end
        check_eq("a5_latency", d, DELIVER_LAT);
      end
    join
    hold_line(1'b1, 2 * CPB);
    drain_compare("a5_byte");
    check_flags("a5");

    // 4-cycle low glitch: START aborts after half a bit
    b0 = busy_cycles;
    hold_line(1'b0, 4);
    hold_line(1'b1, 40);
    check_eq("glitch_busy_cycles", busy_cycles - b0, CPB / 2);
    drain_compare("glitch");
    check_flags("glitch");

    // bad stop bit with break, then a clean byte
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_line(1'b1, CPB);
    check_flags("frame");
    send_frame(8'h11, 1'b1, 1'b0);
    hold_line(1'b1, 2 * CPB);
    drain_compare("after_break");

    // back-to-back bytes with consumer stalled
    set_ready(1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    hold_line(1'b1, 2 * CPB);
    check_eq("ovr_valid_held", rx_bus.O_valid, 1'b1);
    check_eq("ovr_data_held",  rx_bus.O_data, 8'h01);
    check_flags("ovr");
    set_ready(1'b1);
    hold_line(1'b1, 4);
    drain_compare("ovr_drain");
    check_eq("drain_valid_clear", rx_bus.O_valid, 1'b0);
    check_eq("drain_data_kept",   rx_bus.O_data, 8'h01);

    // reset mid-frame with the line low at release
    set_ready(1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold_line(1'b1, 2 * CPB);
    check_eq("pre_reset_valid", rx_bus.O_valid, hold_full);
    hold_line(1'b0, 4 * CPB);
    I_rst = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    check_eq("rst_mid_valid",   rx_bus.O_valid, 1'b0);
    check_eq("rst_mid_busy",    rx_bus.O_busy, 1'b0);
    check_eq("rst_mid_pulses",
             {rx_bus.O_frame_err, rx_bus.O_parity_err, rx_bus.O_overrun}, 3'b000);
    exp_q.delete();
    hold_full = 1'b0;
    rd_idx    = obs_pop;
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    b0 = busy_cycles;
    hold_line(1'b0, 30);
    check_eq("rst_low_no_start", busy_cycles - b0, 0);
    hold_line(1'b1, 3 * CPB);
    set_ready(1'b1);
    send_frame(8'h7E, 1'b1, 1'b0);
    hold_line(1'b1, 2 * CPB);
    drain_compare("after_reset");
    check_flags("after_reset");

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones, so the correct parity bit is 1
    send_frame(8'h07, 1'b1, 1'b0);
    hold_line(1'b1, 2 * CPB);
    drain_compare("par_good");
    send_frame(8'h07, 1'b1, 1'b1);
    hold_line(1'b1, 2 * CPB);
    drain_compare("par_bad");
    check_flags("parity");
`endif

    // randomized frames
    for (int n = 0; n < 14; n++) begin
      logic [7:0] rb;
      logic       rs;
      logic       rp;
      int         gap;
      rb  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 4) != 0);
      rp  = ($urandom_range(0, 4) == 0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      send_frame(rb, rs, rp);
      if (gap > 0) hold_line(1'b1, gap);
    end
    hold_line(1'b1, 3 * CPB);
    drain_compare("rand_byte");
    check_flags("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
